// File: rtl/pipe_pkg.sv
// Shared opcode constants, FSM state type and register-use decode for the
// pipeline hazard controller.
package pipe_pkg;

    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } state_e;

    // True when the opcode reads rs1 from the register file.
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_ITYPE) || (op == OP_LD) || (op == OP_SD) ||
               (op == OP_BEQ)   || (op == OP_RTYPE);
    endfunction

    // True when the opcode reads rs2 from the register file.
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_SD) || (op == OP_BEQ) || (op == OP_RTYPE);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: add one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-beq
// flush of IF/ID, and a full freeze while the data memory has not acked.
// Memory handshake: dmem_valid_o is held while an access is outstanding and
// the access completes in the cycle dmem_ack_i is high; an ack in the same
// cycle as the request is a zero-wait access and costs no stall.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int WAIT_MAX = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       IFID_op_i,
    input  logic [4:0]       IFID_rs1_i,
    input  logic [4:0]       IFID_rs2_i,
    input  logic             IDEX_memread_i,
    input  logic [4:0]       IDEX_rd_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_we_o,
    output logic             dmem_valid_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       dbg_state_o
);

    localparam int WW = $clog2(WAIT_MAX) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;

    logic active;
    logic load_use;
    logic mem_stall;

    // Hazard detection: load-use against the ld in EX, and memory freeze.
    always_comb begin
        active   = (state_q == RUN) || (state_q == MEM_WAIT);
        load_use = IDEX_memread_i && (IDEX_rd_i != 5'd0) &&
                   ((uses_rs1(IFID_op_i) && (IFID_rs1_i == IDEX_rd_i)) ||
                    (uses_rs2(IFID_op_i) && (IFID_rs2_i == IDEX_rd_i)));
        if (state_q == MEM_WAIT) begin
            mem_stall = !dmem_ack_i;
        end else begin
            mem_stall = (state_q == RUN) && dmem_req_i && !dmem_ack_i;
        end
    end

    // Pipeline enables: memory freeze beats load-use, which beats branch flush.
    always_comb begin
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_we_o    = 1'b0;
        memwb_we_o    = 1'b0;
        dmem_valid_o  = 1'b0;
        if (active) begin
            dmem_valid_o = (state_q == MEM_WAIT) || dmem_req_i;
            if (mem_stall) begin
                // Whole pipe frozen; everything else waits.
            end else if (load_use) begin
                // Hold PC and IF/ID, inject a bubble; a taken beq here used
                // stale operands so its flush is dropped.
                idex_bubble_o = 1'b1;
                exmem_we_o    = 1'b1;
                memwb_we_o    = 1'b1;
            end else begin
                pc_we_o      = 1'b1;
                ifid_we_o    = 1'b1;
                exmem_we_o   = 1'b1;
                memwb_we_o   = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end
    end

    // Sequencer next state and memory-wait timeout.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = RUN;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, wait counter and sticky error registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign err_o       = err_q;
    assign dbg_state_o = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .inc_i  (active && !pc_we_o),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .inc_i  (ifid_flush_o),
        .cnt_o  (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int W        = 7 + 1 + CNT_W + CNT_W;

    localparam logic [6:0] EN_IDLE   = 7'b0000000;
    localparam logic [6:0] EN_RUN    = 7'b1100110;
    localparam logic [6:0] EN_LU     = 7'b0001110;
    localparam logic [6:0] EN_FLUSH  = 7'b1110110;
    localparam logic [6:0] EN_FREEZE = 7'b0000001;
    localparam logic [6:0] EN_ACK    = 7'b1100111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [6:0]       op = 7'd0;
    logic [4:0]       rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic             memread = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
    logic             pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, dmem_valid, err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0]       dbg_state;
    logic [6:0]       en;

    int nchecks = 0;
    int nerrors = 0;

    logic [W-1:0] exp_q[$];

    // model state
    bit m_run, m_wait, m_err;
    int m_waited, m_stall, m_flush;

    assign en = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, dmem_valid};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .start_i        (start_i),
        .IFID_op_i      (op),
        .IFID_rs1_i     (rs1),
        .IFID_rs2_i     (rs2),
        .IDEX_memread_i (memread),
        .IDEX_rd_i      (rd),
        .branch_taken_i (br),
        .dmem_req_i     (req),
        .dmem_ack_i     (ack),
        .pc_we_o        (pc_we),
        .ifid_we_o      (ifid_we),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .exmem_we_o     (exmem_we),
        .memwb_we_o     (memwb_we),
        .dmem_valid_o   (dmem_valid),
        .err_o          (err),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [6:0] o, input logic [4:0] r1, input logic [4:0] r2,
                         input logic mr, input logic [4:0] d, input logic b,
                         input logic rq, input logic ak);
        op = o; rs1 = r1; rs2 = r2; memread = mr; rd = d; br = b; req = rq; ack = ak;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_i = 1'b0;
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_run();
        do_reset();
        start_i = 1'b1;
        tick();
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] model_en();
        bit act, u1, u2, lu, ms, v;
        act = m_run || m_wait;
        u1 = op inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011};
        u2 = op inside {7'b0100011, 7'b1100011, 7'b0110011};
        lu = memread && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        ms = m_wait ? !ack : (req && !ack);
        v  = m_wait || req;
        if (!act)    return EN_IDLE;
        if (ms)      return {6'b000000, v};
        if (lu)      return {6'b000111, v};
        return {2'b11, br, 3'b011, v};
    endfunction

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_step(input logic [6:0] e);
        if ((m_run || m_wait) && !e[6] && m_stall < CNT_MAX) m_stall++;
        if (e[4] && m_flush < CNT_MAX) m_flush++;
        if (m_err) begin
        end else if (m_wait) begin
            if (ack) begin
                m_wait = 0; m_run = 1;
            end else begin
                m_waited++;
                if (m_waited == WAIT_MAX) begin
                    m_wait = 0; m_err = 1;
                end
            end
        end else if (m_run) begin
            if (req && !ack) begin
                m_run = 0; m_wait = 1; m_waited = 0;
            end
        end else if (start_i) begin
            m_run = 1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 1'b1;
        drive(7'b0110011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        #3;
        nchecks++;
        if (en !== EN_IDLE || err !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
            nerrors++;
            $display("FAIL reset_vals: en=%b err=%b st=%0d fl=%0d exp en=%b err=0 cnt=0", en, err, stall_cnt, flush_cnt, EN_IDLE);
        end
        start_i = 1'b0;
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_i = 1'b1;
        @(negedge clk);
        nchecks++;
        if (en !== EN_IDLE || dbg_state !== 2'd0) begin
            nerrors++;
            $display("FAIL idle_with_start: en=%b st=%0d exp en=%b st=0", en, dbg_state, EN_IDLE);
        end
        tick();
        @(negedge clk);
        nchecks++;
        if (en !== EN_RUN || stall_cnt !== '0) begin
            nerrors++;
            $display("FAIL first_run: en=%b stall=%0d exp en=%b stall=0", en, stall_cnt, EN_RUN);
        end
        tick();
    endtask

    task automatic test_load_use();
        start_run();
        drive(7'b0110011, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nchecks++;
        if (en !== EN_LU) begin
            nerrors++;
            $display("FAIL lu_bubble: en=%b exp %b", en, EN_LU);
        end
        tick();
        drive(7'b0110011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nchecks++;
        if (en !== EN_RUN || stall_cnt !== 4'd1) begin
            nerrors++;
            $display("FAIL lu_after: en=%b stall=%0d exp en=%b stall=1", en, stall_cnt, EN_RUN);
        end
        tick();
        drive(7'b0110011, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nchecks++;
        if (en !== EN_RUN) begin
            nerrors++;
            $display("FAIL lu_rd0: en=%b exp %b", en, EN_RUN);
        end
        // sd reads rs2; lui-like opcode reads nothing
        drive(7'b0110111, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nchecks++;
        if (en !== EN_RUN) begin
            nerrors++;
            $display("FAIL lu_unused_op: en=%b exp %b", en, EN_RUN);
        end
        tick();
        @(negedge clk);
        nchecks++;
        if (stall_cnt !== 4'd1) begin
            nerrors++;
            $display("FAIL lu_rd0_cnt: stall=%0d exp 1", stall_cnt);
        end
    endtask

    task automatic test_branch();
        start_run();
        drive(7'b1100011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        nchecks++;
        if (en !== EN_FLUSH) begin
            nerrors++;
            $display("FAIL br_flush: en=%b exp %b", en, EN_FLUSH);
        end
        tick();
        drive(7'b1100011, 5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        nchecks++;
        if (en !== EN_LU || flush_cnt !== 4'd1) begin
            nerrors++;
            $display("FAIL br_lu: en=%b flush=%0d exp en=%b flush=1", en, flush_cnt, EN_LU);
        end
        tick();
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nchecks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
            nerrors++;
            $display("FAIL br_cnts: flush=%0d stall=%0d exp 1 1", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        start_run();
        drive(7'b0000011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchecks++;
            if (en !== EN_FREEZE) begin
                nerrors++;
                $display("FAIL mw_freeze%0d: en=%b exp %b", i, en, EN_FREEZE);
            end
            tick();
            // load-use during the wait must not produce a bubble
            drive(7'b0110011, 5'd4, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        end
        drive(7'b0110011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        nchecks++;
        if (en !== EN_ACK || stall_cnt !== 4'd3) begin
            nerrors++;
            $display("FAIL mw_ack: en=%b stall=%0d exp en=%b stall=3", en, stall_cnt, EN_ACK);
        end
        tick();
        drive(7'b0100011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        nchecks++;
        if (en !== EN_ACK || dbg_state !== 2'd1) begin
            nerrors++;
            $display("FAIL mw_zero_wait: en=%b st=%0d exp en=%b st=1", en, dbg_state, EN_ACK);
        end
        tick();
        @(negedge clk);
        nchecks++;
        if (stall_cnt !== 4'd3 || dbg_state !== 2'd1) begin
            nerrors++;
            $display("FAIL mw_zero_wait_cnt: stall=%0d st=%0d exp 3 1", stall_cnt, dbg_state);
        end
    endtask

    task automatic test_timeout();
        start_run();
        drive(7'b0100011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            nchecks++;
            if (en !== EN_FREEZE || err !== 1'b0) begin
                nerrors++;
                $display("FAIL to_wait%0d: en=%b err=%b exp en=%b err=0", i, en, err, EN_FREEZE);
            end
            tick();
        end
        @(negedge clk);
        nchecks++;
        if (err !== 1'b1 || en !== EN_IDLE || stall_cnt !== 4'd5) begin
            nerrors++;
            $display("FAIL to_err: err=%b en=%b stall=%0d exp err=1 en=%b stall=5", err, en, stall_cnt, EN_IDLE);
        end
        drive(7'b0110011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        @(negedge clk);
        nchecks++;
        if (err !== 1'b1 || en !== EN_IDLE) begin
            nerrors++;
            $display("FAIL to_sticky: err=%b en=%b exp err=1 en=%b", err, en, EN_IDLE);
        end
        #2 rst_n = 1'b0;
        #1;
        nchecks++;
        if (err !== 1'b0 || en !== EN_IDLE || stall_cnt !== '0 || dbg_state !== 2'd0) begin
            nerrors++;
            $display("FAIL to_async_rst: err=%b en=%b stall=%0d st=%0d exp all 0", err, en, stall_cnt, dbg_state);
        end
        // reset in the middle of a wait drops the strobe at once
        start_run();
        drive(7'b0000011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        nchecks++;
        if (en !== EN_FREEZE) begin
            nerrors++;
            $display("FAIL mw_pre_rst: en=%b exp %b", en, EN_FREEZE);
        end
        #2 rst_n = 1'b0;
        #1;
        nchecks++;
        if (dmem_valid !== 1'b0 || en !== EN_IDLE) begin
            nerrors++;
            $display("FAIL mw_async_rst: en=%b exp %b", en, EN_IDLE);
        end
        do_reset();
    endtask

    task automatic test_saturation();
        start_run();
        drive(7'b0010011, 5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        @(negedge clk);
        nchecks++;
        if (stall_cnt !== 4'd15 || en !== EN_LU) begin
            nerrors++;
            $display("FAIL stall_sat: stall=%0d en=%b exp 15 %b", stall_cnt, en, EN_LU);
        end
        drive(7'b1100011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        @(negedge clk);
        nchecks++;
        if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin
            nerrors++;
            $display("FAIL flush_sat: flush=%0d stall=%0d exp 15 15", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        logic [6:0] e;
        logic [W-1:0] exp_v, got_v;
        int err_cycles;
        ops[0] = 7'b0010011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
        ops[3] = 7'b1100011; ops[4] = 7'b0110011; ops[5] = 7'b0110111;
        do_reset();
        model_reset();
        err_cycles = 0;
        for (int c = 0; c < 1500; c++) begin
            if (($urandom_range(0, 79) == 0) || err_cycles > 3) begin
                do_reset();
                model_reset();
                err_cycles = 0;
            end
            start_i = ($urandom_range(0, 3) == 0) ? 1'b1 : start_i;
            drive(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
            e = model_en();
            exp_q.push_back({e, 1'(m_err), CNT_W'(m_stall), CNT_W'(m_flush)});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            got_v = {en, err, stall_cnt, flush_cnt};
            nchecks++;
            if (got_v !== exp_v) begin
                nerrors++;
                $display("FAIL random_c%0d: got en=%b err=%b st=%0d fl=%0d exp en=%b err=%b st=%0d fl=%0d",
                         c, got_v[W-1 -: 7], got_v[2*CNT_W], got_v[2*CNT_W-1 -: CNT_W], got_v[CNT_W-1:0],
                         exp_v[W-1 -: 7], exp_v[2*CNT_W], exp_v[2*CNT_W-1 -: CNT_W], exp_v[CNT_W-1:0]);
            end
            model_step(e);
            if (m_err) err_cycles++;
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
